muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide responder beside the combinational ALU in the execute stage.
//  Decode issues an operation with a valid/ready request handshake.
//  The unit computes over XLEN iterations and returns the result with a single-cycle valid pulse.
//  The fixed latency lets the hazard logic stall for a known number of cycles.
// PARAMETERS
//  XLEN  32  operand/result width; also the iteration count
// PORTS
//  clk_i        in   1     clock; all state updates on the rising edge
//  rst_i        in   1     asynchronous, active-high reset
//  req_valid_i  in   1     request present
//  req_ready_o  out  1     unit can accept a request (IDLE only)
//  op_i         in   3     RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                          100 DIV, 101 DIVU, 110 REM, 111 REMU
//  A_i          in   XLEN  rs1 operand (multiplicand / dividend)
//  B_i          in   XLEN  rs2 operand (multiplier / divisor)
//  flush_i      in   1     abort current operation (pipeline flush)
//  res_valid_o  out  1     one-cycle pulse: res_o holds a new result
//  res_o        out  XLEN  result
//  busy_o       out  1     high in CALC, FIX and DONE
// BEHAVIOUR
//  Reset (rst_i high, asynchronous):
//   - state=IDLE; res_o=0, res_valid_o=0, busy_o=0.
//   - req_ready_o=0 while rst_i is high; it is 1 from the first cycle after release.
//  Accept: a rising edge with req_valid_i & req_ready_o & !flush_i.
//   - op_i, A_i and B_i are registered at that edge. Later input changes are ignored.
//  FSM (the accept edge is edge 0):
//   - IDLE -> CALC on accept. The iteration counter loads 0.
//   - CALC runs one shift-add (mul) or restoring shift-subtract (div) step per edge.
//     It does XLEN steps on edges 1..XLEN. The edge that completes step XLEN moves to FIX.
//   - FIX -> DONE on edge XLEN+1. Sign correction/selection is applied and res_o is loaded.
//   - DONE -> IDLE on edge XLEN+2. res_valid_o=1 only in DONE.
//   - Latency: res_valid_o is high XLEN+1 cycles after the accept edge (33 cycles for XLEN=32).
//   - req_ready_o is high again in the cycle after DONE.
//   - Throughput: one op per XLEN+3 cycles.
//  Arithmetic:
//   - Operands are converted to magnitudes. Signedness per op:
//     MULH/DIV/REM both signed; MULHSU A signed, B unsigned; MULHU/DIVU/REMU unsigned.
//   - Multiply forms a 2*XLEN product. MUL returns the low XLEN bits; MULH* return the high XLEN bits.
//   - Quotient sign = sA^sB. Remainder sign = sign of dividend.
//   - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> A_i unmodified. Latency unchanged.
//   - Signed overflow (A=-2^(XLEN-1), B=-1): DIV -> A_i; REM -> 0. Latency unchanged.
//  Flush:
//   - flush_i high at an edge in CALC/FIX/DONE -> IDLE at that edge. res_valid_o stays 0.
//   - res_o is not updated by a flushed operation.
//   - flush_i in IDLE blocks acceptance at that edge.
//  Reset asserted mid-operation: immediate IDLE. No res_valid_o for the aborted op.
//  res_o holds its last value between results. It is never cleared except by reset.
//  req_valid_i while busy: ignored; the requester holds it until req_ready_o.
// TESTING
//  1. MUL A=7, B=0xFFFFFFFD -> res_o=0xFFFFFFEB. res_valid_o pulses exactly 33 cycles after accept, one cycle wide.
//  2. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//     MULH 0x80000000*0x80000000 -> 0x40000000.
//     MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
//  4. DIV 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5.
//     DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
//     All cases keep 33-cycle latency.
//  5. flush_i pulsed 10 cycles after accept -> no res_valid_o, res_o unchanged.
//     req_ready_o=1 next cycle; a new MUL 3*4 returns 12 with normal latency.
//  6. rst_i pulsed mid-CALC -> res_o=0 and req_ready_o=0 immediately.
//     After release, back-to-back requests held valid are accepted every 35 cycles with correct results.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one shift step per cycle, fixed XLEN+3 cycle occupancy.
// Operands become magnitudes at accept; signs are re-applied in FIX.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] A_i,
    input  logic [XLEN-1:0] B_i,
    input  logic            flush_i,
    output logic            res_valid_o,
    output logic [XLEN-1:0] res_o,
    output logic            busy_o
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_ma, r_mb, r_hi, r_lo;
    logic            r_negp, r_nega, r_bz;
    logic            w_accept, w_sa, w_sb, w_na, w_nb;
    logic [XLEN-1:0] w_ma, w_mb, w_hi_nx, w_lo_nx, w_quo, w_rem, w_result;
    logic [XLEN:0]   w_sum, w_trial;
    logic [2*XLEN-1:0] w_prod;
    assign req_ready_o = (r_state == IDLE) && !rst_i;
    assign busy_o      = r_state != IDLE;
    assign w_accept    = req_valid_i && req_ready_o && !flush_i;
    assign w_sa = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
    assign w_sb = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01);
    assign w_na = w_sa && A_i[XLEN-1];
    assign w_nb = w_sb && B_i[XLEN-1];
    assign w_ma = w_na ? -A_i : A_i;
    assign w_mb = w_nb ? -B_i : B_i;
    // {r_hi,r_lo} is the product for multiply, {remainder,quotient/dividend} for divide
    assign w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_ma : {XLEN{1'b0}})};
    assign w_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_mb};
    assign w_hi_nx = !r_op[2] ? w_sum[XLEN:1] :
                     (w_trial[XLEN] ? {r_hi[XLEN-2:0], r_lo[XLEN-1]} : w_trial[XLEN-1:0]);
    assign w_lo_nx = !r_op[2] ? {w_sum[0], r_lo[XLEN-1:1]} : {r_lo[XLEN-2:0], ~w_trial[XLEN]};
    assign w_prod   = r_negp ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quo    = r_bz ? {XLEN{1'b1}} : (r_negp ? -r_lo : r_lo);
    assign w_rem    = r_nega ? -r_hi : r_hi;
    assign w_result = r_op[2] ? (r_op[1] ? w_rem : w_quo) :
                      (r_op[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_negp      <= 1'b0;
            r_nega      <= 1'b0;
            r_bz        <= 1'b0;
            res_o       <= '0;
            res_valid_o <= 1'b0;
        end else begin
            res_valid_o <= 1'b0;
            if (r_state != IDLE && flush_i) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: if (w_accept) begin
                        r_state <= CALC;
                        r_cnt   <= '0;
                        r_op    <= op_i;
                        r_ma    <= w_ma;
                        r_mb    <= w_mb;
                        r_negp  <= w_na ^ w_nb;
                        r_nega  <= w_na;
                        r_bz    <= B_i == '0;
                        r_hi    <= '0;
                        r_lo    <= op_i[2] ? w_ma : w_mb;
                    end
                    CALC: begin
                        r_hi  <= w_hi_nx;
                        r_lo  <= w_lo_nx;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(XLEN - 1)) r_state <= FIX;
                    end
                    FIX: begin
                        res_o       <= w_result;
                        res_valid_o <= 1'b1;
                        r_state     <= DONE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed RV32M vectors checked against literals and a cycle-level arithmetic model.
module tb_muldiv_unit;
    logic        clk = 0, rst = 1, req_valid = 0, flush = 0;
    logic [2:0]  op = 0;
    logic [31:0] a = 0, b = 0;
    logic        req_ready, res_valid, busy;
    logic [31:0] res;
    int checks = 0, passed = 0, cyc = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .op_i(op), .A_i(a), .B_i(b), .flush_i(flush),
        .res_valid_o(res_valid), .res_o(res), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, q;
        logic [63:0] ux, uy, p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
                q = sx / sy; return q[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                q = sx % sy; return q[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // mt counts edges since accept (-1 when idle); result is visible on edge 33
    int mt = -1;
    logic [31:0] mres = 0, mpend = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mt = -1;
            mres = 0;
        end else if (mt < 0) begin
            if (req_valid && !flush) begin
                mt = 0;
                mpend = model_res(op, a, b);
            end
        end else if (flush) begin
            mt = -1;
        end else begin
            mt++;
            if (mt == 33) mres = mpend;
            else if (mt == 34) mt = -1;
        end
    end

    always @(negedge clk) begin
        chk("ready", 32'(req_ready), 32'(mt < 0 && !rst));
        chk("valid", 32'(res_valid), 32'(mt == 33));
        chk("busy", 32'(busy), 32'(mt >= 0));
        chk("res", res, mres);
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit hold, output int acc);
        int n;
        op = o; a = x; b = y; req_valid = 1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (n == 100) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) req_valid = 0;
        a = ~x; b = y ^ 32'h5A5A5A5A;
    endtask

    task automatic wait_res(input logic [31:0] exp, input string name);
        int lat;
        for (lat = 1; lat <= 40; lat++) begin
            @(posedge clk);
            #1;
            if (res_valid) break;
        end
        chk({name, "_latency"}, 32'(lat), 33);
        chk(name, res, exp);
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input string name);
        int t;
        chk({name, "_model"}, model_res(o, x, y), exp);
        issue(o, x, y, 0, t);
        wait_res(exp, name);
    endtask

    initial begin
        int t0, t1, t2;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_res", res, 0);
        chk("reset_ready", 32'(req_ready), 0);
        rst = 0;
        @(negedge clk);
        chk("ready_after_release", 32'(req_ready), 1);
        run(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
        @(posedge clk); #1;
        chk("valid_one_wide", 32'(res_valid), 0);
        run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        run(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
        run(3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, "mulhsu");
        run(3'd1, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, "mulh_neg");
        run(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div");
        run(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem");
        run(3'd5, 32'd100, 32'd7, 32'd14, "divu");
        run(3'd7, 32'd100, 32'd7, 32'd2, "remu");
        run(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, "div_zero");
        run(3'd7, 32'd5, 32'd0, 32'd5, "remu_zero");
        run(3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, "rem_zero");
        run(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        run(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_ovf");
        run(3'd4, 32'd20, 32'hFFFFFFFB, 32'hFFFFFFFC, "div_negb");
        // flush mid-operation: result must not change
        issue(3'd0, 32'd9, 32'd9, 0, t0);
        repeat (9) @(posedge clk);
        #1 flush = 1;
        @(posedge clk);
        #1 flush = 0;
        chk("flush_ready", 32'(req_ready), 1);
        chk("flush_res_kept", res, 32'hFFFFFFFC);
        run(3'd0, 32'd3, 32'd4, 32'd12, "mul_after_flush");
        // flush in IDLE blocks acceptance
        @(negedge clk);
        req_valid = 1; flush = 1;
        @(posedge clk);
        #1;
        chk("flush_idle_block", 32'(busy), 0);
        req_valid = 0; flush = 0;
        // reset mid-CALC
        issue(3'd5, 32'd1000, 32'd3, 0, t0);
        repeat (5) @(posedge clk);
        #1 rst = 1;
        #1;
        chk("rst_mid_res", res, 0);
        chk("rst_mid_ready", 32'(req_ready), 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        // back-to-back with request held valid
        issue(3'd0, 32'd6, 32'd7, 1, t0);
        wait_res(32'd42, "b2b_mul");
        issue(3'd4, 32'hFFFFFF9C, 32'd7, 1, t1);
        chk("b2b_gap1", 32'(t1 - t0), 35);
        wait_res(32'hFFFFFFF2, "b2b_div");
        issue(3'd7, 32'd1000, 32'd7, 0, t2);
        chk("b2b_gap2", 32'(t2 - t1), 35);
        wait_res(32'd6, "b2b_remu");
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
